// File: rtl/alu_issue_stage.sv
// ARM data-processing issue stage: condition check, operand2 shifter, registered ALU handoff, CPSR flags.
// Define ALU_ISSUE_FLAG_BYPASS_EN to forward returning ALU flags into the same-cycle condition/carry evaluation.
module alu_issue_stage #(
   parameter logic [3:0] RESET_NZCV = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [3:0]  rn_addr,
   output logic [3:0]  rm_addr,
   input  logic [31:0] rn_data,
   input  logic [31:0] rm_data,
   output logic        alu_valid,
   input  logic        alu_ready,
   output logic [31:0] operand_a,
   output logic [31:0] operand_b,
   output logic [3:0]  alu_control,
   output logic [3:0]  rd_addr,
   output logic        carry_in,
   output logic        shifter_carry,
   output logic        result_writeback,
   output logic        nzcv_writeback,
   input  logic [3:0]  nzcv_in,
   input  logic        nzcv_in_valid,
   output logic [3:0]  cpsr_nzcv,
   output logic        illegal_instr
);

   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;
   localparam logic [3:0] OP_ADC  = 4'd5;
   localparam logic [3:0] OP_SBC  = 4'd6;
   localparam logic [3:0] OP_RSC  = 4'd7;
   localparam logic [3:0] OP_MOV  = 4'd13;
   localparam logic [3:0] OP_MVN  = 4'd15;

   logic        alu_valid_q, alu_valid_d;
   logic [31:0] operand_a_q, operand_a_d;
   logic [31:0] operand_b_q, operand_b_d;
   logic [3:0]  alu_control_q, alu_control_d;
   logic [3:0]  rd_addr_q, rd_addr_d;
   logic        carry_in_q, carry_in_d;
   logic        shifter_carry_q, shifter_carry_d;
   logic        result_wb_q, result_wb_d;
   logic        nzcv_wb_q, nzcv_wb_d;
   logic        illegal_q, illegal_d;
   logic        flag_pending_q, flag_pending_d;
   logic [3:0]  cpsr_q, cpsr_d;

   logic [3:0]  cond, opcode;
   logic        s_bit, i_bit;
   logic [4:0]  shamt, rot2;
   logic [1:0]  shtype;
   logic [31:0] imm32;

   assign cond    = instr[31:28];
   assign i_bit   = instr[25];
   assign opcode  = instr[24:21];
   assign s_bit   = instr[20];
   assign shamt   = instr[11:7];
   assign shtype  = instr[6:5];
   assign rot2    = {instr[11:8], 1'b0};
   assign imm32   = {24'b0, instr[7:0]};
   assign rn_addr = instr[19:16];
   assign rm_addr = instr[3:0];

   logic [3:0] flags_eff;
   logic       pending_eff;
`ifdef ALU_ISSUE_FLAG_BYPASS_EN
   assign flags_eff   = nzcv_in_valid ? nzcv_in : cpsr_q;
   assign pending_eff = flag_pending_q & ~nzcv_in_valid;
`else
   assign flags_eff   = cpsr_q;
   assign pending_eff = flag_pending_q;
`endif

   logic c_flag;
   assign c_flag = flags_eff[1];

   function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return c;
         4'h3:    return ~c;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return c & ~z;
         4'h9:    return ~c | z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return ~z & (n == v);
         4'hD:    return z | (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Extended vectors carry the last shifted-out bit alongside the result.
   logic [32:0] lsl_ext, lsr_ext, asr_ext;
   logic [31:0] ror_res, imm_res;
   logic [31:0] shift_res;
   logic        shift_co;

   always_comb begin
      lsl_ext   = {1'b0, rm_data} << shamt;
      lsr_ext   = {rm_data, 1'b0} >> shamt;
      asr_ext   = $signed({rm_data, 1'b0}) >>> shamt;
      ror_res   = (rm_data >> shamt) | (rm_data << (6'd32 - {1'b0, shamt}));
      imm_res   = (imm32 >> rot2) | (imm32 << (6'd32 - {1'b0, rot2}));
      shift_res = rm_data;
      shift_co  = c_flag;
      if (i_bit) begin
         shift_res = imm_res;
         shift_co  = (rot2 == 5'd0) ? c_flag : imm_res[31];
      end else begin
         case (shtype)
            2'b00: begin
               if (shamt != 5'd0) begin
                  shift_res = lsl_ext[31:0];
                  shift_co  = lsl_ext[32];
               end
            end
            2'b01: begin
               if (shamt == 5'd0) begin
                  shift_res = 32'd0;
                  shift_co  = rm_data[31];
               end else begin
                  shift_res = lsr_ext[32:1];
                  shift_co  = lsr_ext[0];
               end
            end
            2'b10: begin
               if (shamt == 5'd0) begin
                  shift_res = {32{rm_data[31]}};
                  shift_co  = rm_data[31];
               end else begin
                  shift_res = asr_ext[32:1];
                  shift_co  = asr_ext[0];
               end
            end
            default: begin
               if (shamt == 5'd0) begin
                  shift_res = {c_flag, rm_data[31:1]};
                  shift_co  = rm_data[0];
               end else begin
                  shift_res = ror_res;
                  shift_co  = ror_res[31];
               end
            end
         endcase
      end
   end

   logic illegal_word, rrx, stall, accept, issue;

   always_comb begin
      illegal_word = (instr[27:26] != 2'b00) | (~i_bit & instr[4])
                   | ((opcode[3:2] == 2'b10) & ~s_bit) | (cond == COND_NV);
      rrx          = ~i_bit & (shtype == 2'b11) & (shamt == 5'd0);
      stall        = pending_eff & ((cond != COND_AL) | (opcode == OP_ADC) | (opcode == OP_SBC)
                                    | (opcode == OP_RSC) | rrx | s_bit);
      instr_ready  = ~stall & (~alu_valid_q | alu_ready);
      accept       = instr_valid & instr_ready;
      issue        = accept & ~illegal_word & cond_pass(cond, flags_eff);
   end

   always_comb begin
      alu_valid_d     = alu_valid_q;
      operand_a_d     = operand_a_q;
      operand_b_d     = operand_b_q;
      alu_control_d   = alu_control_q;
      rd_addr_d       = rd_addr_q;
      carry_in_d      = carry_in_q;
      shifter_carry_d = shifter_carry_q;
      result_wb_d     = result_wb_q;
      nzcv_wb_d       = nzcv_wb_q;
      illegal_d       = accept & illegal_word;
      flag_pending_d  = flag_pending_q;
      cpsr_d          = nzcv_in_valid ? nzcv_in : cpsr_q;

      if (alu_ready)
         alu_valid_d = 1'b0;
      if (issue) begin
         alu_valid_d     = 1'b1;
         operand_a_d     = ((opcode == OP_MOV) || (opcode == OP_MVN)) ? shift_res : rn_data;
         operand_b_d     = shift_res;
         alu_control_d   = opcode;
         rd_addr_d       = instr[15:12];
         carry_in_d      = c_flag;
         shifter_carry_d = shift_co;
         result_wb_d     = (opcode[3:2] != 2'b10);
         nzcv_wb_d       = s_bit;
      end

      // A new flag-setting issue outranks a flag return in the same cycle.
      if (issue && s_bit)
         flag_pending_d = 1'b1;
      else if (nzcv_in_valid)
         flag_pending_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_valid_q     <= 1'b0;
         operand_a_q     <= 32'd0;
         operand_b_q     <= 32'd0;
         alu_control_q   <= 4'd0;
         rd_addr_q       <= 4'd0;
         carry_in_q      <= 1'b0;
         shifter_carry_q <= 1'b0;
         result_wb_q     <= 1'b0;
         nzcv_wb_q       <= 1'b0;
         illegal_q       <= 1'b0;
         flag_pending_q  <= 1'b0;
         cpsr_q          <= RESET_NZCV;
      end else begin
         alu_valid_q     <= alu_valid_d;
         operand_a_q     <= operand_a_d;
         operand_b_q     <= operand_b_d;
         alu_control_q   <= alu_control_d;
         rd_addr_q       <= rd_addr_d;
         carry_in_q      <= carry_in_d;
         shifter_carry_q <= shifter_carry_d;
         result_wb_q     <= result_wb_d;
         nzcv_wb_q       <= nzcv_wb_d;
         illegal_q       <= illegal_d;
         flag_pending_q  <= flag_pending_d;
         cpsr_q          <= cpsr_d;
      end
   end

   assign alu_valid        = alu_valid_q;
   assign operand_a        = operand_a_q;
   assign operand_b        = operand_b_q;
   assign alu_control      = alu_control_q;
   assign rd_addr          = rd_addr_q;
   assign carry_in         = carry_in_q;
   assign shifter_carry    = shifter_carry_q;
   assign result_writeback = result_wb_q;
   assign nzcv_writeback   = nzcv_wb_q;
   assign illegal_instr    = illegal_q;
   assign cpsr_nzcv        = cpsr_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hazard/backpressure sequences, random words vs a bit-serial model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = 32'd0;
   logic [3:0]  rn_addr, rm_addr;
   logic [31:0] rn_data = 32'd0, rm_data = 32'd0;
   logic        alu_valid;
   logic        alu_ready = 1'b1;
   logic [31:0] operand_a, operand_b;
   logic [3:0]  alu_control, rd_addr;
   logic        carry_in, shifter_carry, result_writeback, nzcv_writeback;
   logic [3:0]  nzcv_in = 4'd0;
   logic        nzcv_in_valid = 1'b0;
   logic [3:0]  cpsr_nzcv;
   logic        illegal_instr;

   alu_issue_stage #(.RESET_NZCV(4'b0000)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rn_addr(rn_addr), .rm_addr(rm_addr), .rn_data(rn_data), .rm_data(rm_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .operand_a(operand_a), .operand_b(operand_b),
      .alu_control(alu_control), .rd_addr(rd_addr), .carry_in(carry_in),
      .shifter_carry(shifter_carry), .result_writeback(result_writeback),
      .nzcv_writeback(nzcv_writeback), .nzcv_in(nzcv_in), .nzcv_in_valid(nzcv_in_valid),
      .cpsr_nzcv(cpsr_nzcv), .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] w;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [3:0]  f;
      logic        v;
      logic        ill;
      logic [31:0] a;
      logic [31:0] b;
      logic        shc;
      logic        rwb;
      logic        nwb;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc)
         0: return z;             1: return !z;
         2: return c;             3: return !c;
         4: return n;             5: return !n;
         6: return v;             7: return !v;
         8: return c && !z;       9: return !c || z;
         10: return n == v;       11: return n != v;
         12: return !z && n == v; 13: return z || n != v;
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic model_legal(input logic [31:0] w);
      int op;
      op = int'(w[24:21]);
      if (w[31:28] == 4'hF) return 1'b0;
      if (w[27:26] != 2'b00) return 1'b0;
      if (!w[25] && w[4]) return 1'b0;
      if (op >= 8 && op <= 11 && !w[20]) return 1'b0;
      return 1'b1;
   endfunction

   // Shifts one bit position at a time, tracking the bit that falls off.
   task automatic model_op2(input logic [31:0] w, input logic [31:0] rm, input logic c,
                            output logic [31:0] res, output logic co);
      int amt;
      co = c;
      if (w[25]) begin
         res = {24'b0, w[7:0]};
         for (int i = 0; i < 2 * int'(w[11:8]); i++) res = {res[0], res[31:1]};
         if (w[11:8] != 4'd0) co = res[31];
      end else begin
         amt = int'(w[11:7]);
         res = rm;
         case (w[6:5])
            2'b00: for (int i = 0; i < amt; i++) begin co = res[31]; res = res << 1; end
            2'b01: begin
               if (amt == 0) amt = 32;
               for (int i = 0; i < amt; i++) begin co = res[0]; res = res >> 1; end
            end
            2'b10: begin
               if (amt == 0) amt = 32;
               for (int i = 0; i < amt; i++) begin co = res[0]; res = {res[31], res[31:1]}; end
            end
            default: begin
               if (amt == 0) begin
                  co = rm[0];
                  res = {c, rm[31:1]};
               end else begin
                  for (int i = 0; i < amt; i++) begin co = res[0]; res = {res[0], res[31:1]}; end
               end
            end
         endcase
      end
   endtask

   task automatic pulse_flags(input logic [3:0] f);
      nzcv_in_valid = 1'b1;
      nzcv_in = f;
      instr_valid = 1'b0;
      alu_ready = 1'b1;
      tick();
      nzcv_in_valid = 1'b0;
   endtask

   task automatic run_one(input string tag, input vec_t t);
      pulse_flags(t.f);
      instr_valid = 1'b1;
      instr = t.w;
      rn_data = t.rn;
      rm_data = t.rm;
      @(negedge clk);
      chk({tag, ".instr_ready"}, 32'(instr_ready), 32'd1);
      chk({tag, ".rn_rm_addr"}, {24'd0, rn_addr, rm_addr}, {24'd0, t.w[19:16], t.w[3:0]});
      chk({tag, ".cpsr"}, 32'(cpsr_nzcv), 32'(t.f));
      tick();
      instr_valid = 1'b0;
      chk({tag, ".alu_valid"}, 32'(alu_valid), 32'(t.v));
      chk({tag, ".illegal"}, 32'(illegal_instr), 32'(t.ill));
      if (t.v) begin
         chk({tag, ".operand_a"}, operand_a, t.a);
         chk({tag, ".operand_b"}, operand_b, t.b);
         chk({tag, ".ctrl_rd"}, {24'd0, alu_control, rd_addr}, {24'd0, t.w[24:21], t.w[15:12]});
         chk({tag, ".carry_in"}, 32'(carry_in), 32'(t.f[1]));
         chk({tag, ".shifter_carry"}, 32'(shifter_carry), 32'(t.shc));
         chk({tag, ".wb"}, {30'd0, result_writeback, nzcv_writeback}, {30'd0, t.rwb, t.nwb});
      end
      tick();
      chk({tag, ".illegal_pulse"}, 32'(illegal_instr), 32'd0);
      chk({tag, ".drain"}, 32'(alu_valid), 32'd0);
   endtask

   task automatic hazard_seq(input string tag, input logic [3:0] f, input logic exp_issue);
      int cycles;
      pulse_flags(4'b0000);
      instr_valid = 1'b1;
      instr = 32'hE1510002;
      rn_data = 32'd5;
      rm_data = 32'd5;
      tick();
      chk({tag, ".cmp_issued"}, 32'(alu_valid), 32'd1);
      instr = 32'h02821001;
      rn_data = 32'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, ".stall"}, 32'(instr_ready), 32'd0);
         tick();
      end
      nzcv_in_valid = 1'b1;
      nzcv_in = f;
      cycles = 0;
      while (cycles < 4) begin
         @(negedge clk);
         if (instr_ready) break;
         cycles++;
         tick();
         nzcv_in_valid = 1'b0;
      end
`ifdef ALU_ISSUE_FLAG_BYPASS_EN
      chk({tag, ".release_cycles"}, 32'(cycles), 32'd0);
`else
      chk({tag, ".release_cycles"}, 32'(cycles), 32'd1);
`endif
      tick();
      nzcv_in_valid = 1'b0;
      instr_valid = 1'b0;
      chk({tag, ".issued"}, 32'(alu_valid), 32'(exp_issue));
      chk({tag, ".illegal"}, 32'(illegal_instr), 32'd0);
      chk({tag, ".cpsr"}, 32'(cpsr_nzcv), 32'(f));
      if (exp_issue) begin
         chk({tag, ".ctrl"}, 32'(alu_control), 32'd4);
         chk({tag, ".operand_a"}, operand_a, 32'd9);
      end
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      logic [31:0] res;
      logic        co;

      tbl[0]  = '{32'hE2821001, 32'd5, 32'd0, 4'b0000, 1'b1, 1'b0, 32'd5, 32'd1, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{32'hE3B00102, 32'd0, 32'd0, 4'b0000, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{32'hE1A00021, 32'd0, 32'h80000000, 4'b0000, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{32'hE0010392, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{32'hE1A00041, 32'd0, 32'h80000001, 4'b0000, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{32'hE1A00061, 32'd0, 32'h00000003, 4'b0010, 1'b1, 1'b0, 32'h80000001, 32'h80000001, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{32'hE0810002, 32'd7, 32'd9, 4'b0000, 1'b1, 1'b0, 32'd7, 32'd9, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{32'hE0810202, 32'd1, 32'hF0000001, 4'b0010, 1'b1, 1'b0, 32'd1, 32'h00000010, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{32'hE08100A2, 32'd0, 32'd3, 4'b0000, 1'b1, 1'b0, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{32'hE0810462, 32'd2, 32'h000000AB, 4'b0000, 1'b1, 1'b0, 32'd2, 32'hAB000000, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{32'hE28104FF, 32'd3, 32'd0, 4'b0000, 1'b1, 1'b0, 32'd3, 32'hFF000000, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{32'hE1010002, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{32'hF2821001, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{32'hE1510002, 32'd5, 32'd5, 4'b0010, 1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{32'h12821001, 32'd0, 32'd0, 4'b0100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{32'hE5910000, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{32'h02821001, 32'd8, 32'd0, 4'b0100, 1'b1, 1'b0, 32'd8, 32'd1, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{32'hE2821001, 32'd4, 32'd0, 4'b0010, 1'b1, 1'b0, 32'd4, 32'd1, 1'b1, 1'b1, 1'b0};

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset.alu_valid", 32'(alu_valid), 32'd0);
      chk("reset.illegal", 32'(illegal_instr), 32'd0);
      chk("reset.cpsr", 32'(cpsr_nzcv), 32'd0);
      chk("reset.operands", operand_a | operand_b, 32'd0);
      chk("reset.instr_ready", 32'(instr_ready), 32'd1);
      tick();

      for (int i = 0; i < 18; i++) run_one($sformatf("vec%0d", i), tbl[i]);

      hazard_seq("hazard_eq", 4'b0100, 1'b1);
      hazard_seq("hazard_ne", 4'b0000, 1'b0);

      pulse_flags(4'b0000);
      instr_valid = 1'b1;
      instr = 32'hE2821001;
      rn_data = 32'd5;
      alu_ready = 1'b0;
      tick();
      chk("bp.issued", 32'(alu_valid), 32'd1);
      instr = 32'hE2831002;
      rn_data = 32'h77;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp.ready_low", 32'(instr_ready), 32'd0);
         chk("bp.hold_a", operand_a, 32'd5);
         chk("bp.hold_b", operand_b, 32'd1);
         chk("bp.hold_valid", 32'(alu_valid), 32'd1);
         tick();
      end
      alu_ready = 1'b1;
      @(negedge clk);
      chk("bp.ready_release", 32'(instr_ready), 32'd1);
      tick();
      chk("bp.next_a", operand_a, 32'h77);
      chk("bp.next_b", operand_b, 32'd2);
      instr = 32'hE2841003;
      rn_data = 32'h55;
      tick();
      chk("b2b.a", operand_a, 32'h55);
      chk("b2b.b", operand_b, 32'd3);
      chk("b2b.valid", 32'(alu_valid), 32'd1);
      instr_valid = 1'b0;
      alu_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset.valid", 32'(alu_valid), 32'd0);
      chk("midreset.a", operand_a, 32'd0);
      alu_ready = 1'b1;
      tick();

      for (int k = 0; k < 200; k++) begin
         r.w = $urandom;
         if ($urandom_range(15, 0) != 0) r.w[27:26] = 2'b00;
         if (!r.w[25] && $urandom_range(7, 0) != 0) r.w[4] = 1'b0;
         if (r.w[24:23] == 2'b10 && $urandom_range(7, 0) != 0) r.w[20] = 1'b1;
         if (r.w[31:28] == 4'hF && $urandom_range(3, 0) != 0) r.w[31:28] = 4'hE;
         r.rn = $urandom;
         r.rm = $urandom;
         r.f = 4'($urandom_range(15, 0));
         r.ill = !model_legal(r.w);
         r.v = !r.ill && model_cond(r.w[31:28], r.f);
         model_op2(r.w, r.rm, r.f[1], res, co);
         r.b = res;
         r.shc = co;
         r.a = (r.w[24:21] == 4'd13 || r.w[24:21] == 4'd15) ? res : r.rn;
         r.rwb = !(r.w[24:21] >= 4'd8 && r.w[24:21] <= 4'd11);
         r.nwb = r.w[20];
         run_one($sformatf("rnd%0d", k), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
